// File: rtl/cricket_match_ctrl.sv
// cricket_match_ctrl: innings/match sequencer that decodes LFSR delivery outcomes into score, balls and result.
// Ports: clk_fpga/reset (sync, active-high); delivery strobe with 4-bit shift outcome; teamSwitch strobe starts innings 2;
// binaryRuns/binaryWickets/balls/target/innings show current innings; inningOver/gameOver/winner/tie report match state.
// Build option: FREE_HIT_EN enables the free-hit rule after a no-ball.
module cricket_match_ctrl #(
    parameter int unsigned BALLS_PER_INNINGS = 30,
    parameter int unsigned MAX_WICKETS       = 10
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        delivery,
    input  logic [3:0]  shift,
    input  logic        teamSwitch,
    output logic [7:0]  binaryRuns,
    output logic [3:0]  binaryWickets,
    output logic [15:0] balls,
    output logic [8:0]  target,
    output logic        innings,
    output logic        inningOver,
    output logic        gameOver,
    output logic        winner,
    output logic        tie
);
    typedef enum logic [1:0] {INN1, BREAK, INN2, GAME_OVER} state_t;

    localparam logic [15:0] BALL_LIM = 16'(BALLS_PER_INNINGS);
    localparam logic [3:0]  WKT_LIM  = 4'(MAX_WICKETS);

    state_t      state_q, state_d;
    logic [7:0]  runs_q, runs_d, runs_n;
    logic [3:0]  wkts_q, wkts_d, wkts_n;
    logic [15:0] balls_q, balls_d, balls_n;
    logic [8:0]  target_q, target_d, runs_sum;
    logic        innings_q, innings_d, over_q, over_d, game_q, game_d;
    logic        winner_q, winner_d, tie_q, tie_d, fh_q, fh_d, fh_next;
    logic [3:0]  run_add;
    logic        legal, wkt_hit, chase, level;

    always_comb run_add = shift <= 4'd2  ? 4'd0 :
                          shift <= 4'd6  ? 4'd1 :
                          shift <= 4'd9  ? 4'd2 :
                          shift == 4'd10 ? 4'd3 :
                          shift == 4'd11 ? 4'd4 :
                          shift == 4'd12 ? 4'd6 :
                          shift <= 4'd14 ? 4'd1 : 4'd0;

    assign legal = (shift != 4'd13) && (shift != 4'd14);

`ifdef FREE_HIT_EN
    // A wide keeps a pending free hit alive; any other delivery consumes it.
    assign wkt_hit = (shift == 4'd15) && !fh_q;
    assign fh_next = (shift == 4'd14) ? 1'b1 : (shift == 4'd13) ? fh_q : 1'b0;
`else
    assign wkt_hit = (shift == 4'd15);
    assign fh_next = 1'b0;
`endif

    assign runs_sum = {1'b0, runs_q} + {5'b0, run_add};
    assign runs_n   = runs_sum[8] ? 8'hFF : runs_sum[7:0];
    assign wkts_n   = wkts_q + {3'b0, wkt_hit};
    assign balls_n  = balls_q + {15'b0, legal};
    assign chase    = {1'b0, runs_n} >= target_q;
    assign level    = ({1'b0, runs_n} + 9'd1) == target_q;

    always_comb begin
        state_d   = state_q;
        runs_d    = runs_q;
        wkts_d    = wkts_q;
        balls_d   = balls_q;
        target_d  = target_q;
        innings_d = innings_q;
        over_d    = over_q;
        game_d    = game_q;
        winner_d  = winner_q;
        tie_d     = tie_q;
        fh_d      = fh_q;
        case (state_q)
            INN1, INN2: begin
                if (delivery) begin
                    runs_d  = runs_n;
                    wkts_d  = wkts_n;
                    balls_d = balls_n;
                    fh_d    = fh_next;
                    if (state_q == INN1 && (wkts_n == WKT_LIM || balls_n == BALL_LIM)) begin
                        state_d  = BREAK;
                        target_d = {1'b0, runs_n} + 9'd1;
                        over_d   = 1'b1;
                        fh_d     = 1'b0;
                    end else if (state_q == INN2 && (chase || wkts_n == WKT_LIM || balls_n == BALL_LIM)) begin
                        state_d  = GAME_OVER;
                        over_d   = 1'b1;
                        game_d   = 1'b1;
                        winner_d = chase;
                        tie_d    = !chase && level;
                        fh_d     = 1'b0;
                    end
                end
            end
            BREAK: begin
                if (teamSwitch) begin
                    state_d   = INN2;
                    runs_d    = 8'd0;
                    wkts_d    = 4'd0;
                    balls_d   = 16'd0;
                    innings_d = 1'b1;
                    over_d    = 1'b0;
                    fh_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q   <= INN1;
            runs_q    <= 8'd0;
            wkts_q    <= 4'd0;
            balls_q   <= 16'd0;
            target_q  <= 9'd0;
            innings_q <= 1'b0;
            over_q    <= 1'b0;
            game_q    <= 1'b0;
            winner_q  <= 1'b0;
            tie_q     <= 1'b0;
            fh_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            runs_q    <= runs_d;
            wkts_q    <= wkts_d;
            balls_q   <= balls_d;
            target_q  <= target_d;
            innings_q <= innings_d;
            over_q    <= over_d;
            game_q    <= game_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
            fh_q      <= fh_d;
        end
    end

    assign binaryRuns    = runs_q;
    assign binaryWickets = wkts_q;
    assign balls         = balls_q;
    assign target        = target_q;
    assign innings       = innings_q;
    assign inningOver    = over_q;
    assign gameOver      = game_q;
    assign winner        = winner_q;
    assign tie           = tie_q;
endmodule

// File: tb/tb_cricket_match_ctrl.sv
// tb_cricket_match_ctrl: scoreboard bench for cricket_match_ctrl with directed plan items and random play.
module tb_cricket_match_ctrl;
    logic        clk_fpga = 1'b0;
    logic        reset = 1'b0, delivery = 1'b0, teamSwitch = 1'b0;
    logic [3:0]  shift = 4'd0;
    logic [7:0]  binaryRuns;
    logic [3:0]  binaryWickets;
    logic [15:0] balls;
    logic [8:0]  target;
    logic        innings, inningOver, gameOver, winner, tie;

    cricket_match_ctrl #(.BALLS_PER_INNINGS(30), .MAX_WICKETS(10)) dut (
        .clk_fpga(clk_fpga), .reset(reset), .delivery(delivery), .shift(shift),
        .teamSwitch(teamSwitch), .binaryRuns(binaryRuns), .binaryWickets(binaryWickets),
        .balls(balls), .target(target), .innings(innings), .inningOver(inningOver),
        .gameOver(gameOver), .winner(winner), .tie(tie)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        int runs, wkts, balls, target, inn, over, game, winner, tie;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0;
    int run_tab[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 1, 1, 0};
    int m_st, m_runs, m_wkts, m_balls, m_target, m_inn, m_winner, m_tie;
`ifdef FREE_HIT_EN
    int m_fh;
`endif

    task automatic chk(string nm, int act, int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: states 0=innings 1, 1=break, 2=innings 2, 3=match over.
    task automatic m_step(bit d, int sh, bit ts, bit rs);
        int add;
        bit legal, wk;
        if (rs) begin
            m_st = 0; m_runs = 0; m_wkts = 0; m_balls = 0; m_target = 0;
            m_inn = 0; m_winner = 0; m_tie = 0;
`ifdef FREE_HIT_EN
            m_fh = 0;
`endif
        end else if ((m_st == 0 || m_st == 2) && d) begin
            add   = run_tab[sh];
            legal = (sh < 13) || (sh == 15);
            wk    = (sh == 15);
`ifdef FREE_HIT_EN
            if (m_fh != 0) wk = 0;
            m_fh = (sh == 14) ? 1 : (sh == 13) ? m_fh : 0;
`endif
            m_runs  = (m_runs + add > 255) ? 255 : m_runs + add;
            m_wkts  = m_wkts + int'(wk);
            m_balls = m_balls + int'(legal);
            if (m_st == 0 && (m_wkts == 10 || m_balls == 30)) begin
                m_st = 1;
                m_target = m_runs + 1;
`ifdef FREE_HIT_EN
                m_fh = 0;
`endif
            end else if (m_st == 2) begin
                if (m_runs >= m_target) begin
                    m_st = 3; m_winner = 1;
                end else if (m_wkts == 10 || m_balls == 30) begin
                    m_st = 3; m_winner = 0;
                    m_tie = (m_runs == m_target - 1) ? 1 : 0;
                end
            end
        end else if (m_st == 1 && ts) begin
            m_st = 2; m_runs = 0; m_wkts = 0; m_balls = 0; m_inn = 1;
`ifdef FREE_HIT_EN
            m_fh = 0;
`endif
        end
    endtask

    task automatic strobe(bit d, int sh, bit ts, bit rs);
        exp_t e;
        delivery = d; shift = 4'(sh); teamSwitch = ts; reset = rs;
        m_step(d, sh, ts, rs);
        e.runs = m_runs; e.wkts = m_wkts; e.balls = m_balls; e.target = m_target;
        e.inn = m_inn; e.over = int'(m_st == 1 || m_st == 3); e.game = int'(m_st == 3);
        e.winner = m_winner; e.tie = m_tie;
        exp_q.push_back(e);
        @(negedge clk_fpga);
        delivery = 1'b0; teamSwitch = 1'b0; reset = 1'b0;
    endtask

    task automatic deliver(int sh);
        strobe(1'b1, sh, 1'b0, 1'b0);
    endtask

    task automatic rst();
        strobe(1'b0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: any strobe presented at a clock edge yields one registered response to check.
    always begin
        exp_t e;
        @(posedge clk_fpga);
        if (delivery || teamSwitch || reset) begin
            @(negedge clk_fpga);
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_runs", int'(binaryRuns), e.runs);
                chk("sb_wickets", int'(binaryWickets), e.wkts);
                chk("sb_balls", int'(balls), e.balls);
                chk("sb_target", int'(target), e.target);
                chk("sb_innings", int'(innings), e.inn);
                chk("sb_inningOver", int'(inningOver), e.over);
                chk("sb_gameOver", int'(gameOver), e.game);
                chk("sb_winner", int'(winner), e.winner);
                chk("sb_tie", int'(tie), e.tie);
            end
        end
    end

    initial begin
        int r;
        @(negedge clk_fpga);
        rst(); rst();
        // Reset mid-innings
        deliver(12); deliver(12); deliver(11); deliver(3);
        chk("pre_reset_runs", int'(binaryRuns), 17);
        strobe(1'b1, 12, 1'b0, 1'b1); rst();
        chk("post_reset_runs", int'(binaryRuns), 0);
        chk("post_reset_balls", int'(balls), 0);
        deliver(11);
        chk("after_reset_four_runs", int'(binaryRuns), 4);
        chk("after_reset_four_balls", int'(balls), 1);
        // Full innings of singles, then a chase of sixes
        rst();
        repeat (30) deliver(3);
        chk("inn1_runs30", int'(binaryRuns), 30);
        chk("inn1_balls30", int'(balls), 30);
        chk("inn1_over", int'(inningOver), 1);
        deliver(3);
        chk("ball31_ignored", int'(balls), 30);
        strobe(1'b0, 0, 1'b1, 1'b0);
        chk("inn2_target31", int'(target), 31);
        chk("inn2_innings", int'(innings), 1);
        chk("inn2_runs0", int'(binaryRuns), 0);
        repeat (6) deliver(12);
        chk("chase_runs36", int'(binaryRuns), 36);
        chk("chase_gameover", int'(gameOver), 1);
        chk("chase_winner", int'(winner), 1);
        chk("chase_tie", int'(tie), 0);
        // Wide and no-ball
        rst();
        deliver(13); deliver(14);
        chk("extras_runs", int'(binaryRuns), 2);
        chk("extras_balls", int'(balls), 0);
        // All out, then switch with simultaneous delivery
        rst();
        repeat (10) deliver(15);
        chk("allout_wkts", int'(binaryWickets), 10);
        chk("allout_balls", int'(balls), 10);
        chk("allout_over", int'(inningOver), 1);
        strobe(1'b1, 12, 1'b1, 1'b0);
        chk("allout_target1", int'(target), 1);
        chk("allout_switch_runs", int'(binaryRuns), 0);
        chk("allout_switch_wkts", int'(binaryWickets), 0);
        // Wicket after no-ball
        rst();
        deliver(14); deliver(15);
        chk("fh_runs", int'(binaryRuns), 1);
        chk("fh_balls", int'(balls), 1);
`ifdef FREE_HIT_EN
        chk("fh_wkts", int'(binaryWickets), 0);
`else
        chk("fh_wkts", int'(binaryWickets), 1);
`endif
        // Saturation and tie at 255 vs target 256
        rst();
        repeat (260) deliver(13);
        chk("sat_runs", int'(binaryRuns), 255);
        repeat (30) deliver(0);
        chk("sat_target", int'(target), 256);
        strobe(1'b0, 0, 1'b1, 1'b0);
        repeat (260) deliver(14);
        repeat (30) deliver(1);
        chk("sat_gameover", int'(gameOver), 1);
        chk("sat_tie", int'(tie), 1);
        chk("sat_winner", int'(winner), 0);
        // Random play
        rst();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) rst();
            else if (r < 75) strobe(1'b1, $urandom_range(0, 15), $urandom_range(0, 9) == 0, 1'b0);
            else if (r < 85) strobe(1'b0, $urandom_range(0, 15), 1'b1, 1'b0);
            else @(negedge clk_fpga);
        end
        repeat (3) @(negedge clk_fpga);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cricket_match_ctrl.md
# cricket_match_ctrl

Match sequencer for the FPGA cricket game. It takes a delivery strobe and the 4-bit outcome nibble from the LFSR and decodes each delivery into runs, extras or a wicket. It sequences innings 1, the team-switch break, innings 2 and the end of the match, then reports the score, the ball count and the winner to the display/LED logic.

## Interface
Parameters:
- BALLS_PER_INNINGS, 30: legal balls per innings (5 overs).
- MAX_WICKETS, 10: wickets that end an innings.

Ports:
- clk_fpga  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high; returns block to start of innings 1.
- delivery  in  1  single-cycle strobe, already debounced and synchronised upstream.
- shift  in  4  LFSR low nibble; sampled in the cycle `delivery`=1.
- teamSwitch  in  1  single-cycle strobe; starts innings 2 from BREAK.
- binaryRuns  out  8  runs of current innings, saturating at 255.
- binaryWickets  out  4  wickets of current innings.
- balls  out  16  legal balls bowled in current innings.
- target  out  9  innings-1 runs + 1; 0 during innings 1.
- innings  out  1  0 = innings 1 (team A bats), 1 = innings 2 (team B).
- inningOver  out  1  high in BREAK and GAME_OVER.
- gameOver  out  1  high in GAME_OVER.
- winner  out  1  0 = team A, 1 = team B; valid only when gameOver=1 and tie=0.
- tie  out  1  scores level at end of match.

## Operation
States:
- INN1 (reset state).
- BREAK.
- INN2.
- GAME_OVER.

Outcome decode, applied only when `delivery`=1 in INN1/INN2:
- 0–2: dot; ball +1.
- 3–6: single; runs +1, ball +1.
- 7–9: double; runs +2, ball +1.
- 10: triple; runs +3, ball +1.
- 11: four; runs +4, ball +1.
- 12: six; runs +6, ball +1.
- 13: wide; runs +1, ball not counted.
- 14: no-ball; runs +1, ball not counted.
- 15: wicket; wickets +1, ball +1.

Arithmetic: runs add with saturation at 255. target = saturated innings-1 runs + 1, held in 9 bits.

Innings end, evaluated on the post-update values of the same delivery:
- INN1 → BREAK when wickets == MAX_WICKETS or balls == BALLS_PER_INNINGS. target is latched on the same edge.
- INN2 → GAME_OVER when runs ≥ target (chase won, checked first), or wickets == MAX_WICKETS, or balls == BALLS_PER_INNINGS.
- A chase reached on a wide/no-ball ends the match, even when the ball limit was not reached.

Winner decision in GAME_OVER:
- runs ≥ target: winner=1.
- runs == target−1: tie=1.
- otherwise: winner=0.

BREAK: runs/wickets/balls hold innings-1 values for display. `teamSwitch` clears them, sets innings=1 and enters INN2.

Ignored inputs:
- `delivery` in BREAK/GAME_OVER.
- `teamSwitch` in INN1/INN2/GAME_OVER.
- Simultaneous `delivery` and `teamSwitch`: only the one valid for the current state acts.

GAME_OVER is held until reset.

## Timing
- All outputs are registered. Counters, state and flags update on the clk_fpga edge that samples `delivery`; results are visible the next cycle (latency 1).
- Back-to-back `delivery` strobes on consecutive cycles are each processed.
- The last legal ball updates counters and asserts inningOver on the same edge.
- Reset values: binaryRuns=0, binaryWickets=0, balls=0, target=0, innings=0, inningOver=0, gameOver=0, winner=0, tie=0, state INN1, free-hit flag 0.
- Reset wins over any simultaneous strobe. Reset mid-innings discards all progress.

## Configuration
- FREE_HIT_EN defined: a no-ball (14) sets a free-hit flag.
  - On the next counted delivery, outcome 15 scores as a dot ball (ball +1, wickets unchanged).
  - Wides (13) keep the flag set; any other outcome clears it.
  - Innings change and reset clear it.
- FREE_HIT_EN undefined: no flag; 15 is always a wicket.

## Test plan
- Reset asserted 2 cycles mid-INN1 at runs=17 → all outputs 0, INN1; the next delivery with shift=11 gives runs=4, balls=1.
- 30 deliveries shift=3 → runs=30, balls=30, inningOver=1 after the 30th strobe; a 31st delivery leaves all counters unchanged.
- Delivery shift=13, then shift=14 → runs +2 in total, balls unchanged.
- Ten consecutive shift=15 → wickets=10, balls=10, inningOver=1 on the 10th. Then teamSwitch → innings=1, counters 0, target=1.
- Innings 1 ends at 30 runs (target=31); teamSwitch; six deliveries shift=12 → runs=36 after the 6th, gameOver=1, winner=1, tie=0.
- FREE_HIT_EN build: shift=14 then shift=15 → runs=1, wickets=0, balls=1. Same stimulus without the macro → wickets=1, balls=1.
